fft_output_reorder: RTL and testbench

- Reader end of the serial output stream from the final pipelined FFT stage.
- The final stage emits each N-point frame as 17-bit complex samples in bit-reversed index order. This block buffers each frame and re-emits it in natural index order, one sample per clock.
- Uses a ping-pong pair of N-entry banks so a new frame can be written while the previous frame is read out.

---
 rtl/fft_output_reorder.sv | 214 +++++++++++++++++++++
 tb/tb_fft_output_reorder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_reorder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fft_output_reorder
//
// Purpose:
//   Receives the serial output of the final pipelined FFT stage. Each frame
//   arrives in bit-reversed index order. The block stores each frame in one
//   bank of a ping-pong buffer and re-emits it in natural index order, one
//   sample per clock. The next frame is written into the other bank while the
//   current one is read out.
//
// Optional feature macro: REORDER_SAT16_EN
//   When defined, output components are saturated to the signed 16-bit range
//   and sign-extended back to DW bits. A Sat_flag output is then present and
//   marks samples where either component was clipped.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous active-high reset
//   In_valid   in   input sample valid
//   In_start   in   first sample of a frame (qualified by In_valid)
//   In_re/im   in   DW-bit signed sample, bit-reversed order
//   Out_valid  out  natural-order sample valid
//   Out_re/im  out  DW-bit signed sample, natural order
//   Out_index  out  natural bin index of the current output
//   Out_last   out  high with bin N-1
//   Sat_flag   out  (REORDER_SAT16_EN only) sample was saturated
//   Frame_drop out  one-cycle pulse when a partial frame is discarded
// -----------------------------------------------------------------------------
module fft_output_reorder #(
    parameter int LOG2N = 5,
    parameter int DW    = 17
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   In_valid,
    input  logic                   In_start,
    input  logic signed [DW-1:0]   In_re,
    input  logic signed [DW-1:0]   In_im,
    output logic                   Out_valid,
    output logic signed [DW-1:0]   Out_re,
    output logic signed [DW-1:0]   Out_im,
    output logic [LOG2N-1:0]       Out_index,
    output logic                   Out_last,
`ifdef REORDER_SAT16_EN
    output logic                   Sat_flag,
`endif
    output logic                   Frame_drop
);

    localparam int               N    = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    // Write side state
    logic [2*DW-1:0]   r_mem [2*N];
    logic [LOG2N-1:0]  r_wcnt;
    logic              r_in_frame;
    logic              r_wbank;
    logic              r_drop;

    // Read side state
    logic              r_rd_active;
    logic [LOG2N-1:0]  r_rcnt;
    logic              r_rbank;

    // Output registers
    logic              r_out_valid;
    logic signed [DW-1:0] r_out_re;
    logic signed [DW-1:0] r_out_im;
    logic [LOG2N-1:0]  r_out_index;
    logic              r_out_last;

    logic              w_accept;
    logic [LOG2N-1:0]  w_k;
    logic [LOG2N:0]    w_wr_addr;
    logic              w_handoff;
    logic              w_drop;
    logic [2*DW-1:0]   w_rd_word;
    logic signed [DW-1:0] w_rd_re;
    logic signed [DW-1:0] w_rd_im;
    logic signed [DW-1:0] w_out_re;
    logic signed [DW-1:0] w_out_im;

    // In_start always restarts the count at k=0, so r_in_frame is exactly
    // "count is 1..N-1", which is the partial-frame condition for a drop.
    assign w_accept  = In_valid && (In_start || r_in_frame);
    assign w_k       = In_start ? '0 : r_wcnt;
    assign w_wr_addr = {r_wbank, bitrev(w_k)};
    assign w_handoff = w_accept && (w_k == LAST);
    assign w_drop    = In_valid && In_start && r_in_frame;

    assign w_rd_word = r_mem[{r_rbank, r_rcnt}];
    assign w_rd_re   = w_rd_word[2*DW-1:DW];
    assign w_rd_im   = w_rd_word[DW-1:0];

`ifdef REORDER_SAT16_EN
    localparam logic signed [DW-1:0] SAT_MAX = DW'(32767);
    localparam logic signed [DW-1:0] SAT_MIN = DW'(-32768);

    function automatic logic signed [DW-1:0] sat16(input logic signed [DW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    function automatic logic sat16_hit(input logic signed [DW-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    logic r_sat;
    logic w_sat;

    assign w_out_re = sat16(w_rd_re);
    assign w_out_im = sat16(w_rd_im);
    assign w_sat    = sat16_hit(w_rd_re) || sat16_hit(w_rd_im);
    assign Sat_flag = r_sat;
`else
    assign w_out_re = w_rd_re;
    assign w_out_im = w_rd_im;
`endif

    // Sample storage: data only, no reset
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_mem[w_wr_addr] <= {In_re, In_im};
        end
    end

    // Write side control
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wcnt     <= '0;
            r_in_frame <= 1'b0;
            r_wbank    <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (w_accept) begin
                if (w_handoff) begin
                    r_wcnt     <= '0;
                    r_in_frame <= 1'b0;
                    r_wbank    <= ~r_wbank;
                end else begin
                    r_wcnt     <= w_k + 1'b1;
                    r_in_frame <= 1'b1;
                end
            end
        end
    end

    // Read side and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rd_active <= 1'b0;
            r_rcnt      <= '0;
            r_rbank     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
`ifdef REORDER_SAT16_EN
            r_sat       <= 1'b0;
`endif
        end else begin
            if (r_rd_active) begin
                r_out_valid <= 1'b1;
                r_out_re    <= w_out_re;
                r_out_im    <= w_out_im;
                r_out_index <= r_rcnt;
                r_out_last  <= (r_rcnt == LAST);
`ifdef REORDER_SAT16_EN
                r_sat       <= w_sat;
`endif
                r_rcnt      <= r_rcnt + 1'b1;
                if (r_rcnt == LAST) begin
                    r_rd_active <= 1'b0;
                end
            end else begin
                r_out_valid <= 1'b0;
                r_out_re    <= '0;
                r_out_im    <= '0;
                r_out_index <= '0;
                r_out_last  <= 1'b0;
`ifdef REORDER_SAT16_EN
                r_sat       <= 1'b0;
`endif
            end
            // A hand-off can only coincide with the final read of the previous
            // frame, so it takes precedence and yields back-to-back frames.
            if (w_handoff) begin
                r_rd_active <= 1'b1;
                r_rcnt      <= '0;
                r_rbank     <= r_wbank;
            end
        end
    end

    assign Out_valid  = r_out_valid;
    assign Out_re     = r_out_re;
    assign Out_im     = r_out_im;
    assign Out_index  = r_out_index;
    assign Out_last   = r_out_last;
    assign Frame_drop = r_drop;

endmodule

// File: tb/tb_fft_output_reorder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fft_output_reorder
//
// Self-checking bench for fft_output_reorder. A reference model collects each
// accepted frame in arrival order and, when the frame completes, pushes the
// natural-order samples (with their expected output cycle) to a scoreboard
// queue. A monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_fft_output_reorder;

    localparam int LOG2N = 5;
    localparam int DW    = 17;
    localparam int N     = 1 << LOG2N;
    localparam int NV    = 6;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 In_valid;
    logic                 In_start;
    logic signed [DW-1:0] In_re;
    logic signed [DW-1:0] In_im;
    logic                 Out_valid;
    logic signed [DW-1:0] Out_re;
    logic signed [DW-1:0] Out_im;
    logic [LOG2N-1:0]     Out_index;
    logic                 Out_last;
    logic                 Frame_drop;
`ifdef REORDER_SAT16_EN
    logic                 Sat_flag;
`endif

    fft_output_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .In_valid   (In_valid),
        .In_start   (In_start),
        .In_re      (In_re),
        .In_im      (In_im),
        .Out_valid  (Out_valid),
        .Out_re     (Out_re),
        .Out_im     (Out_im),
        .Out_index  (Out_index),
        .Out_last   (Out_last),
`ifdef REORDER_SAT16_EN
        .Sat_flag   (Sat_flag),
`endif
        .Frame_drop (Frame_drop)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int     re;
        int     im;
        int     idx;
        bit     last;
        bit     sat;
        longint cyc;
    } exp_t;

    typedef struct {
        int in_re;
        int in_im;
        int exp_re;
        int exp_im;
        bit exp_sat;
    } vec_t;

    exp_t   q[$];
    vec_t   tab[NV];
    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    int     exp_drops = 0;
    int     obs_drops = 0;

    // reference model state
    bit     m_in_frame = 1'b0;
    int     m_k = 0;
    int     b_re[N];
    int     b_im[N];
    bit     b_sat[N];

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int brev(input int a);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            if (a[i]) r = r | (1 << (LOG2N - 1 - i));
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input bit s, input int ere, input int eim, input bit esat);
        exp_t e;
        if (s) begin
            if (m_in_frame && m_k > 0) exp_drops++;
            m_k = 0;
            m_in_frame = 1'b1;
        end else if (!m_in_frame) begin
            return;
        end
        b_re[m_k]  = ere;
        b_im[m_k]  = eim;
        b_sat[m_k] = esat;
        m_k++;
        if (m_k == N) begin
            for (int i = 0; i < N; i++) begin
                e.re   = b_re[brev(i)];
                e.im   = b_im[brev(i)];
                e.sat  = b_sat[brev(i)];
                e.idx  = i;
                e.last = (i == N - 1);
                e.cyc  = cyc + 2 + i;
                q.push_back(e);
            end
            m_in_frame = 1'b0;
            m_k = 0;
        end
    endtask

    task automatic drive(input bit v, input bit s, input int re, input int im,
                         input int ere, input int eim, input bit esat);
        @(negedge Clk);
        #1;
        In_valid = v;
        In_start = s;
        In_re    = DW'(re);
        In_im    = DW'(im);
        if (v) model_accept(s, ere, eim, esat);
    endtask

    task automatic send(input bit v, input bit s, input int re, input int im);
        drive(v, s, re, im, re, im, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic end_check(input string name);
        chk({name, "_pending"}, q.size(), 0);
        chk({name, "_drops"}, obs_drops, exp_drops);
    endtask

    // Output monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Frame_drop) obs_drops++;
            if (Out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: index %0d re %0d with nothing expected", Out_index, Out_re);
                end else begin
                    e = q.pop_front();
                    chk("out_index", Out_index, e.idx);
                    chk("out_re", Out_re, e.re);
                    chk("out_im", Out_im, e.im);
                    chk("out_last", Out_last, e.last);
                    chk("out_cycle", cyc, e.cyc);
`ifdef REORDER_SAT16_EN
                    chk("sat_flag", Sat_flag, e.sat);
`endif
                end
            end else begin
                chk("idle_zero", (Out_re == 0 && Out_im == 0 && Out_index == 0 && Out_last == 0) ? 1 : 0, 1);
`ifdef REORDER_SAT16_EN
                chk("idle_sat", Sat_flag, 0);
`endif
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef REORDER_SAT16_EN
        tab[0] = '{40000, -40000, 32767, -32768, 1'b1};
        tab[1] = '{32767, -32768, 32767, -32768, 1'b0};
        tab[2] = '{32768, 0, 32767, 0, 1'b1};
        tab[3] = '{0, -32769, 0, -32768, 1'b1};
        tab[4] = '{-65536, 65535, -32768, 32767, 1'b1};
        tab[5] = '{123, -456, 123, -456, 1'b0};
`else
        tab[0] = '{40000, -40000, 40000, -40000, 1'b0};
        tab[1] = '{32767, -32768, 32767, -32768, 1'b0};
        tab[2] = '{32768, 0, 32768, 0, 1'b0};
        tab[3] = '{0, -32769, 0, -32769, 1'b0};
        tab[4] = '{-65536, 65535, -65536, 65535, 1'b0};
        tab[5] = '{123, -456, 123, -456, 1'b0};
`endif

        Reset = 1'b1; In_valid = 1'b0; In_start = 1'b0; In_re = '0; In_im = '0;
        repeat (3) @(negedge Clk);
        #1;
        chk("reset_valid", Out_valid, 0);
        chk("reset_index", Out_index, 0);
        chk("reset_drop", Frame_drop, 0);
        Reset = 1'b0;

        // single gapless frame
        for (int k = 0; k < N; k++) send(1'b1, k == 0, k, -k);
        idle(40);
        end_check("basic");

        // two frames back to back
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < N; k++) send(1'b1, k == 0, 1000 * (f + 1) + k, -(1000 * (f + 1) + k));
        idle(40);
        end_check("b2b");

        // input gap on every other cycle
        for (int k = 0; k < N; k++) begin
            send(1'b1, k == 0, 200 + k, -(200 + k));
            if (k != N - 1) send(1'b0, 1'b0, 7777, 7777);
        end
        idle(40);
        end_check("gaps");

        // resync after 10 samples
        for (int k = 0; k < 10; k++) send(1'b1, k == 0, 5000 + k, 5000 + k);
        for (int k = 0; k < N; k++) send(1'b1, k == 0, 300 + k, -(300 + k));
        idle(40);
        end_check("resync");
        chk("resync_drop_count", obs_drops, 1);

        // saturation / passthrough vectors
        for (int k = 0; k < N; k++) begin
            if (k < NV) drive(1'b1, k == 0, tab[k].in_re, tab[k].in_im,
                              tab[k].exp_re, tab[k].exp_im, tab[k].exp_sat);
            else        send(1'b1, k == 0, k, -k);
        end
        idle(40);
        end_check("sat_table");

        // reset during output index 12
        for (int k = 0; k < N; k++) send(1'b1, k == 0, 400 + k, -(400 + k));
        idle(14);
        chk("abort_at_index", Out_index, 12);
        Reset = 1'b1;
        q.delete();
        m_in_frame = 1'b0;
        m_k = 0;
        @(negedge Clk);
        #1;
        chk("abort_valid", Out_valid, 0);
        chk("abort_index", Out_index, 0);
        chk("abort_re", Out_re, 0);
        Reset = 1'b0;
        for (int k = 0; k < 40; k++) send(1'b1, 1'b0, 9000 + k, 9000 + k);
        idle(40);
        end_check("ignore_no_start");
        for (int k = 0; k < N; k++) send(1'b1, k == 0, 600 + k, -(600 + k));
        idle(40);
        end_check("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
